// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// FETCH_MISALIGN_CHK_EN adds the ST_HALT state used by misaligned-redirect checking.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

`ifdef FETCH_MISALIGN_CHK_EN
  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} fetch_state_e;
`else
  typedef enum logic {ST_RUN = 1'b0} fetch_state_e;
`endif

  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam fetch_entry_t FILL_ENTRY = '{pc: 32'h0000_0000, instr: NOP_INSTR};

  function automatic logic is_misaligned(input logic [31:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding fetched words with their PCs; flush has priority over push/pop.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter type entry_t = fetch_pkg::fetch_entry_t,
  parameter entry_t FILL = entry_t'('0)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  entry_t                   din,
  output entry_t                   dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  // A full FIFO can still accept a word when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? FILL & entry_t'('0) : mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= FILL;
    end else if (do_push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: PC register, redirect priority and handshake into the prefetch FIFO.
// Define FETCH_MISALIGN_CHK_EN to halt with a sticky misalign_err on misaligned redirects.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        misalign_err
`endif
);

  fetch_state_e               state;
  fetch_state_e               next_state;
  logic [31:0]                fetch_pc;
  logic [31:0]                next_pc;
  logic                       fetch_en;
  logic                       set_err;
  logic                       pop;
  logic                       full;
  logic                       empty;
  logic [$clog2(DEPTH):0]     count;
  fetch_entry_t               head;
  fetch_entry_t               tail;

  assign instr_addr = fetch_pc;
  assign out_valid  = (count != '0);
  assign pop        = ~empty & out_ready;
  assign out_instr  = head.instr;
  assign out_pc     = head.pc;
  assign tail       = '{pc: fetch_pc, instr: instr_data};

  // Next-state, next-PC and fetch enable; redirect outranks fetching.
  always_comb begin
    next_state = state;
    next_pc    = fetch_pc;
    fetch_en   = 1'b0;
    set_err    = 1'b0;
    case (state)
      ST_RUN: begin
        if (redirect_valid) begin
`ifdef FETCH_MISALIGN_CHK_EN
          next_pc = redirect_pc;
          if (is_misaligned(redirect_pc)) begin
            next_state = ST_HALT;
            set_err    = 1'b1;
          end else begin
            next_state = ST_RUN;
          end
`else
          next_pc = {redirect_pc[31:2], 2'b00};
`endif
        end else if (!full || pop) begin
          fetch_en = 1'b1;
          next_pc  = fetch_pc + PC_STEP;
        end else begin
          next_pc = fetch_pc;
        end
      end
`ifdef FETCH_MISALIGN_CHK_EN
      ST_HALT: next_state = ST_HALT;
`endif
      default: next_state = ST_RUN;
    endcase
  end

  // State and PC registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_RUN;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= next_state;
      fetch_pc <= next_pc;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_err <= 1'b0;
    end else if (set_err) begin
      misalign_err <= 1'b1;
    end else begin
      misalign_err <= misalign_err;
    end
  end
`else
  logic unused_err;
  assign unused_err = set_err;
`endif

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t),
    .FILL    (FILL_ENTRY)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fetch_en),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (tail),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (default and FETCH_MISALIGN_CHK_EN builds).
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr_addr, instr_data, out_instr, out_pc, redirect_pc;
  logic        out_valid, out_ready, redirect_valid;
  logic [31:0] instr_addr2, instr_data2, out_instr2, out_pc2;
  logic        out_valid2;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        misalign_err, misalign_err2;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    case (a)
      32'h0000_0000: rom_fn = 32'h0020_81B3;   // add x3,x1,x2
      32'h0000_0004: rom_fn = 32'h4011_8233;   // sub x4,x3,x1
      32'h0000_0008: rom_fn = 32'h0041_2023;   // sw  x4,0(x2)
      32'h0000_000C: rom_fn = 32'h0001_2283;   // lw  x5,0(x2)
      32'h0000_0010: rom_fn = 32'h0012_8313;   // addi x6,x5,1
      default:       rom_fn = {a[15:0], 16'h0013};
    endcase
  endfunction

  assign instr_data  = rom_fn(instr_addr);
  assign instr_data2 = rom_fn(instr_addr2);

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .instr_addr(instr_addr), .instr_data(instr_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef FETCH_MISALIGN_CHK_EN
    , .misalign_err(misalign_err)
`endif
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut2 (
    .clk(clk), .reset(reset), .instr_addr(instr_addr2), .instr_data(instr_data2),
    .out_valid(out_valid2), .out_ready(1'b1), .out_instr(out_instr2), .out_pc(out_pc2),
    .redirect_valid(1'b0), .redirect_pc(32'h0000_0000)
`ifdef FETCH_MISALIGN_CHK_EN
    , .misalign_err(misalign_err2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds reset for two edges and releases it mid-cycle; the next edge is the first fetch.
  task automatic do_reset();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] exp2 [3];
    exp2[0] = 32'hFFFF_FFF8;
    exp2[1] = 32'hFFFF_FFFC;
    exp2[2] = 32'h0000_0000;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Reset state, then streaming with ready high.
    do_reset();
    chk("rst_addr", instr_addr, 32'h0);
    chk1("rst_valid", out_valid, 1'b0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_addr2", instr_addr2, 32'hFFFF_FFF8);
`ifdef FETCH_MISALIGN_CHK_EN
    chk1("rst_err", misalign_err, 1'b0);
`endif
    for (int k = 0; k < 5; k++) begin
      step();
      chk1("stream_valid", out_valid, 1'b1);
      chk("stream_pc", out_pc, 32'(4 * k));
      chk("stream_instr", out_instr, rom_fn(32'(4 * k)));
      chk("stream_addr", instr_addr, 32'(4 * (k + 1)));
      if (k < 3) begin
        chk("wrap_pc", out_pc2, exp2[k]);
        chk("wrap_instr", out_instr2, rom_fn(exp2[k]));
      end
    end

    // Backpressure: FIFO fills, fetch stalls at 0x10, head holds.
    out_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 6; k++) step();
    chk1("bp_valid", out_valid, 1'b1);
    chk("bp_pc", out_pc, 32'h0);
    chk("bp_instr", out_instr, 32'h0020_81B3);
    chk("bp_addr", instr_addr, 32'h10);
    out_ready = 1'b1;
    for (int k = 1; k < 6; k++) begin
      step();
      chk("drain_pc", out_pc, 32'(4 * k));
      chk("drain_instr", out_instr, rom_fn(32'(4 * k)));
    end

    // Redirect with three entries buffered and ready high.
    out_ready = 1'b0;
    do_reset();
    step(); step(); step();
    chk("pre_redir_addr", instr_addr, 32'h0C);
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h18;
    step();
    redirect_valid = 1'b0;
    chk1("redir_valid_t1", out_valid, 1'b0);
    chk("redir_addr_t1", instr_addr, 32'h18);
    step();
    chk1("redir_valid_t2", out_valid, 1'b1);
    chk("redir_pc_t2", out_pc, 32'h18);
    chk("redir_instr_t2", out_instr, rom_fn(32'h18));

    // Back-to-back redirects: the last one wins.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_pc    = 32'h30;
    step();
    redirect_valid = 1'b0;
    chk1("b2b_valid", out_valid, 1'b0);
    chk("b2b_addr", instr_addr, 32'h30);
    step();
    chk("b2b_pc", out_pc, 32'h30);

    // Misaligned redirect target.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1A;
    step();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    chk1("mis_err", misalign_err, 1'b1);
    chk("mis_addr", instr_addr, 32'h1A);
    for (int k = 0; k < 10; k++) begin
      chk1("mis_halt_valid", out_valid, 1'b0);
      step();
    end
    chk("mis_addr_hold", instr_addr, 32'h1A);
    reset = 1'b0;
    #1;
    chk1("mis_rst_err", misalign_err, 1'b0);
    chk1("mis_rst_valid", out_valid, 1'b0);
    reset = 1'b1;
`else
    chk1("mis_valid_t1", out_valid, 1'b0);
    chk("mis_addr", instr_addr, 32'h18);
    step();
    chk1("mis_valid_t2", out_valid, 1'b1);
    chk("mis_pc", out_pc, 32'h18);
    step();
    chk("mis_next_pc", out_pc, 32'h1C);
`endif

    // Asynchronous reset mid-stream with a full FIFO.
    out_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 5; k++) step();
    chk1("full_valid", out_valid, 1'b1);
    reset = 1'b0;
    #1;
    chk1("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_addr", instr_addr, 32'h0);
    chk("async_rst_pc", out_pc, 32'h0);
    step();
    reset = 1'b1;
    step();
    chk1("restart_valid", out_valid, 1'b1);
    chk("restart_pc", out_pc, 32'h0);
    chk("restart_addr", instr_addr, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
